organ_note_sequencer: RTL and testbench
=======================================

ORGAN_NOTE_SEQUENCER -- requirements
Module: organ_note_sequencer

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, input clock frequency used for divide-count computation.
REQ-002 SHALL have parameter NOTE_CYCLES, default 12_500_000, clocks each melody note sounds (>=1).
REQ-003 SHALL have parameter GAP_CYCLES, default 1_250_000, silent clocks after each melody note (>=1).
REQ-004 SHALL have ports: inclk  in  1  sole clock; Reset  in  1  asynchronous active-high reset.
REQ-005 SHALL have ports: start  in  1  begin melody; stop  in  1  abort melody; manual_en  in  1  play manual_note while held; manual_note  in  3  note index 0..7 (Do..Do').
REQ-006 SHALL have ports: div_clk_count  out  32  half-period count for the arbitrary clock divider; div_reset  out  1  holds divider silent when high; busy  out  1  melody in progress; done  out  1  one-cycle melody-complete pulse; note_idx  out  3  current melody position.

Function
REQ-007 SHALL implement FSM states IDLE, MANUAL, PLAY, GAP; all outputs registered (one-cycle latency from sampled inputs).
REQ-008 SHALL map note index n to div_clk_count = floor(CLK_HZ/(2*f_n)) - 1, f = {523,587,659,698,783,880,987,1046} Hz; at 50 MHz: {47800,42588,37935,35815,31927,28408,25328,23899}.
REQ-009 IDLE: div_reset=1, busy=0, div_clk_count holds last value; start -> PLAY with note_idx=0; else manual_en -> MANUAL; start has priority over manual_en.
REQ-010 MANUAL: div_reset=0, div_clk_count=table[manual_note] re-sampled every cycle; manual_en low -> IDLE; start -> PLAY (idx 0).
REQ-011 PLAY: div_reset=0, busy=1, div_clk_count=table[melody[note_idx]]; after exactly NOTE_CYCLES cycles in PLAY -> GAP.
REQ-012 GAP: div_reset=1, busy=1; after exactly GAP_CYCLES cycles -> PLAY with note_idx+1, or, if note_idx = SEQ_LEN-1, -> IDLE with done=1 for that one cycle.
REQ-013 stop in PLAY or GAP -> IDLE next cycle, note_idx=0, done stays 0; stop has priority over timer expiry; stop in IDLE/MANUAL ignored.
REQ-014 start while busy ignored; manual_en while busy ignored.
REQ-015 Duration timer SHALL be 32-bit, reloaded on every state entry, never wrapping.

Reset
REQ-016 Reset high SHALL immediately force IDLE regardless of state: div_clk_count=0, div_reset=1, busy=0, done=0, note_idx=0, timer=0.
REQ-017 First start after Reset release SHALL behave as REQ-009.

Configuration
REQ-018 With ORGAN_SEQ_LOOP_EN defined, last GAP expiry SHALL pulse done and go to PLAY with note_idx=0 (busy stays 1) until stop or Reset.
REQ-019 Without ORGAN_SEQ_LOOP_EN, behaviour per REQ-012 (single pass).

Structure
REQ-020 Shared package organ_pkg SHALL hold: state enum type, note frequency table, constant function computing divide count from CLK_HZ and frequency, SEQ_LEN=8, melody ROM (default ascending scale 0..7).
REQ-021 Sub-module organ_dur_timer (load, count, expire pulse) SHALL implement the duration timer; all else in top.

Verification (CLK_HZ=50_000_000, NOTE_CYCLES=4, GAP_CYCLES=2)
REQ-022 Reset mid-PLAY -> next sample div_reset=1, busy=0, note_idx=0, div_clk_count=0.
REQ-023 start pulse -> busy=1 next cycle, div_clk_count=47800 for 4 cycles, div_reset=1 for 2, then 42588; done=1 exactly once at cycle 48 after start; busy=0 after.
REQ-024 manual_en=1, manual_note=5 -> div_clk_count=28408, div_reset=0 next cycle; change to 7 -> 23899 next cycle; manual_en=0 -> div_reset=1.
REQ-025 start and manual_en same cycle in IDLE -> PLAY; stop at note 3 PLAY -> IDLE next cycle, done never asserted.
REQ-026 start during PLAY -> ignored, sequence timing unchanged.
REQ-027 ORGAN_SEQ_LOOP_EN defined, start -> done pulses at cycles 48 and 96, busy stays 1, note_idx wraps 7->0.

Source files
------------

// File: rtl/organ_pkg.sv
// Shared definitions for the organ note sequencer: FSM state type, note
// frequency table, divide-count helper, melody length and melody ROM.
package organ_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MANUAL = 2'd1,
    ST_PLAY   = 2'd2,
    ST_GAP    = 2'd3
  } state_t;

  // Number of notes in the melody
  localparam int unsigned SEQ_LEN = 32'd8;

  // Note frequencies in Hz, Do..Do'
  localparam int unsigned NOTE_FREQ_HZ [8] = '{
    32'd523, 32'd587, 32'd659, 32'd698, 32'd783, 32'd880, 32'd987, 32'd1046
  };

  // Melody ROM: note index played at each melody position (ascending scale)
  localparam logic [2:0] MELODY [SEQ_LEN] = '{
    3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7
  };

  // Half-period count for the divider: floor(clk/(2*f)) - 1
  function automatic logic [31:0] calc_div_count(input int unsigned clk_hz,
                                                 input int unsigned freq_hz);
    return 32'(clk_hz / (32'd2 * freq_hz)) - 32'd1;
  endfunction

endpackage

// File: rtl/organ_dur_timer.sv
// Duration timer for the organ note sequencer. Loaded with (cycles - 1) on
// every state entry, counts down to zero and stops there (never wraps).
// o_expire is high while the count sits at zero, i.e. on the last cycle of
// the timed interval.
module organ_dur_timer (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic [31:0] i_load_val,
  output logic        o_expire
);

  logic [31:0] r_count;

  // Down-counter: reload on request, otherwise decrement and saturate at zero
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= 32'd0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != 32'd0) begin
      r_count <= r_count - 32'd1;
    end else begin
      r_count <= r_count;
    end
  end

  assign o_expire = (r_count == 32'd0);

endmodule

// File: rtl/organ_note_sequencer.sv
// Organ note sequencer: drives an external clock divider either from a
// manually selected note or through a fixed melody (note / silent gap).
// Optional build macro: ORGAN_SEQ_LOOP_EN -- when defined the melody repeats
// until stop or Reset instead of playing a single pass.
module organ_note_sequencer
  import organ_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 32'd50_000_000,
  parameter int unsigned NOTE_CYCLES = 32'd12_500_000,
  parameter int unsigned GAP_CYCLES  = 32'd1_250_000
) (
  input  logic        inclk,
  input  logic        Reset,
  input  logic        start,
  input  logic        stop,
  input  logic        manual_en,
  input  logic [2:0]  manual_note,
  output logic [31:0] div_clk_count,
  output logic        div_reset,
  output logic        busy,
  output logic        done,
  output logic [2:0]  note_idx
);

  // Divide counts per note index, resolved at elaboration time
  localparam logic [31:0] DIV_TABLE [8] = '{
    calc_div_count(CLK_HZ, NOTE_FREQ_HZ[0]), calc_div_count(CLK_HZ, NOTE_FREQ_HZ[1]),
    calc_div_count(CLK_HZ, NOTE_FREQ_HZ[2]), calc_div_count(CLK_HZ, NOTE_FREQ_HZ[3]),
    calc_div_count(CLK_HZ, NOTE_FREQ_HZ[4]), calc_div_count(CLK_HZ, NOTE_FREQ_HZ[5]),
    calc_div_count(CLK_HZ, NOTE_FREQ_HZ[6]), calc_div_count(CLK_HZ, NOTE_FREQ_HZ[7])
  };

  localparam logic [2:0] LAST_IDX = 3'(SEQ_LEN - 32'd1);

  state_t      r_state, w_next_state;
  logic [31:0] r_div_count, w_next_div_count;
  logic        r_div_reset, w_next_div_reset;
  logic        r_busy, w_next_busy;
  logic        r_done, w_next_done;
  logic [2:0]  r_note_idx, w_next_idx;
  logic [2:0]  w_idx_inc;
  logic        w_tmr_load;
  logic [31:0] w_tmr_val;
  logic        w_tmr_expire;

  assign w_idx_inc = r_note_idx + 3'd1;

  organ_dur_timer u_dur_timer (
    .i_clk      (inclk),
    .i_rst      (Reset),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_expire   (w_tmr_expire)
  );

  // Reload the timer on every state change with the length of the new state
  always_comb begin
    w_tmr_load = (w_next_state != r_state);
    w_tmr_val  = 32'd0;
    case (w_next_state)
      ST_PLAY: w_tmr_val = NOTE_CYCLES - 32'd1;
      ST_GAP:  w_tmr_val = GAP_CYCLES - 32'd1;
      default: w_tmr_val = 32'd0;
    endcase
  end

  // Next-state and next-output decode; outputs default to silent/idle
  always_comb begin
    w_next_state     = r_state;
    w_next_div_count = r_div_count;
    w_next_div_reset = 1'b1;
    w_next_busy      = 1'b0;
    w_next_done      = 1'b0;
    w_next_idx       = r_note_idx;
    case (r_state)
      ST_IDLE, ST_MANUAL: begin
        if (start) begin
          w_next_state     = ST_PLAY;
          w_next_idx       = 3'd0;
          w_next_div_count = DIV_TABLE[MELODY[0]];
          w_next_div_reset = 1'b0;
          w_next_busy      = 1'b1;
        end else if (manual_en) begin
          w_next_state     = ST_MANUAL;
          w_next_div_count = DIV_TABLE[manual_note];
          w_next_div_reset = 1'b0;
        end else begin
          w_next_state     = ST_IDLE;
        end
      end
      ST_PLAY: begin
        if (stop) begin
          w_next_state = ST_IDLE;
          w_next_idx   = 3'd0;
        end else if (w_tmr_expire) begin
          w_next_state = ST_GAP;
          w_next_busy  = 1'b1;
        end else begin
          w_next_div_count = DIV_TABLE[MELODY[r_note_idx]];
          w_next_div_reset = 1'b0;
          w_next_busy      = 1'b1;
        end
      end
      ST_GAP: begin
        if (stop) begin
          w_next_state = ST_IDLE;
          w_next_idx   = 3'd0;
        end else if (w_tmr_expire && (r_note_idx == LAST_IDX)) begin
          w_next_done = 1'b1;
          w_next_idx  = 3'd0;
`ifdef ORGAN_SEQ_LOOP_EN
          w_next_state     = ST_PLAY;
          w_next_div_count = DIV_TABLE[MELODY[0]];
          w_next_div_reset = 1'b0;
          w_next_busy      = 1'b1;
`else
          w_next_state     = ST_IDLE;
`endif
        end else if (w_tmr_expire) begin
          w_next_state     = ST_PLAY;
          w_next_idx       = w_idx_inc;
          w_next_div_count = DIV_TABLE[MELODY[w_idx_inc]];
          w_next_div_reset = 1'b0;
          w_next_busy      = 1'b1;
        end else begin
          w_next_busy = 1'b1;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_idx   = 3'd0;
      end
    endcase
  end

  // State and registered outputs; Reset forces idle/silent immediately
  always_ff @(posedge inclk or posedge Reset) begin
    if (Reset) begin
      r_state     <= ST_IDLE;
      r_div_count <= 32'd0;
      r_div_reset <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_note_idx  <= 3'd0;
    end else begin
      r_state     <= w_next_state;
      r_div_count <= w_next_div_count;
      r_div_reset <= w_next_div_reset;
      r_busy      <= w_next_busy;
      r_done      <= w_next_done;
      r_note_idx  <= w_next_idx;
    end
  end

  assign div_clk_count = r_div_count;
  assign div_reset     = r_div_reset;
  assign busy          = r_busy;
  assign done          = r_done;
  assign note_idx      = r_note_idx;

endmodule

// File: tb/tb_organ_note_sequencer.sv
// Directed scoreboard bench for organ_note_sequencer (NOTE_CYCLES=4,
// GAP_CYCLES=2). Expected output snapshots are queued as stimulus is driven
// and popped one per clock, sampled 1 time unit after the rising edge.
module tb_organ_note_sequencer;

  localparam logic [31:0] EXP_DIV [8] = '{
    32'd47800, 32'd42588, 32'd37935, 32'd35815,
    32'd31927, 32'd28408, 32'd25328, 32'd23899
  };

  logic        inclk = 1'b0;
  logic        Reset;
  logic        start;
  logic        stop;
  logic        manual_en;
  logic [2:0]  manual_note;
  logic [31:0] div_clk_count;
  logic        div_reset;
  logic        busy;
  logic        done;
  logic [2:0]  note_idx;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] cnt;
    bit          chk_cnt;
    logic        dr;
    logic        bsy;
    logic        dn;
    logic [2:0]  idx;
    bit          chk_idx;
  } exp_t;

  exp_t sb[$];

  organ_note_sequencer #(
    .CLK_HZ      (32'd50_000_000),
    .NOTE_CYCLES (32'd4),
    .GAP_CYCLES  (32'd2)
  ) dut (
    .inclk         (inclk),
    .Reset         (Reset),
    .start         (start),
    .stop          (stop),
    .manual_en     (manual_en),
    .manual_note   (manual_note),
    .div_clk_count (div_clk_count),
    .div_reset     (div_reset),
    .busy          (busy),
    .done          (done),
    .note_idx      (note_idx)
  );

  always #5 inclk = ~inclk;

  task automatic push(input string tag, input logic [31:0] cnt, input bit chk_cnt,
                      input logic dr, input logic bsy, input logic dn,
                      input logic [2:0] idx, input bit chk_idx);
    exp_t e;
    e.tag = tag; e.cnt = cnt; e.chk_cnt = chk_cnt; e.dr = dr;
    e.bsy = bsy; e.dn = dn; e.idx = idx; e.chk_idx = chk_idx;
    sb.push_back(e);
  endtask

  // One full melody pass: per note 4 sounding samples then 2 silent ones
  task automatic push_melody(input string tag, input logic first_done, input int n_samples);
    for (int k = 0; k < n_samples; k++) begin
      logic [2:0] n;
      n = 3'(k / 6);
      if ((k % 6) < 4)
        push(tag, EXP_DIV[n], 1'b1, 1'b0, 1'b1, (k == 0) ? first_done : 1'b0, n, 1'b1);
      else
        push(tag, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, n, 1'b1);
    end
  endtask

  task automatic compare_pop();
    exp_t e;
    logic [37:0] obs;
    logic [37:0] exv;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL scoreboard_empty observed=%0d expected=nonzero", sb.size());
    end
    if (sb.size() != 0) begin
      e   = sb.pop_front();
      obs = {e.chk_cnt ? div_clk_count : 32'd0, div_reset, busy, done,
             e.chk_idx ? note_idx : 3'd0};
      exv = {e.chk_cnt ? e.cnt : 32'd0, e.dr, e.bsy, e.dn,
             e.chk_idx ? e.idx : 3'd0};
      assert (obs === exv) else begin
        errors++;
        $error("FAIL %s observed cnt=%0d dr=%b busy=%b done=%b idx=%0d expected cnt=%0d dr=%b busy=%b done=%b idx=%0d",
               e.tag, obs[37:6], obs[5], obs[4], obs[3], obs[2:0],
               exv[37:6], exv[5], exv[4], exv[3], exv[2:0]);
      end
    end
  endtask

  task automatic tick();
    @(posedge inclk);
    #1;
    compare_pop();
  endtask

  initial begin
    Reset = 1'b1; start = 1'b0; stop = 1'b0; manual_en = 1'b0; manual_note = 3'd0;
    #3;
    push("reset_state", 32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1);
    compare_pop();
    @(negedge inclk);
    Reset = 1'b0;

    // stop in IDLE is ignored
    stop = 1'b1;
    push("idle_stop_ignored", 32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1);
    tick();
    stop = 1'b0;

    // manual play
    manual_en = 1'b1; manual_note = 3'd5;
    push("manual_5", 32'd28408, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    tick();
    stop = 1'b1;
    push("manual_stop_ignored", 32'd28408, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    tick();
    stop = 1'b0; manual_note = 3'd7;
    push("manual_7", 32'd23899, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    tick();
    manual_en = 1'b0;
    push("manual_off", 32'd23899, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1);
    tick();

    // start beats manual_en; manual_en held during play is ignored; stop at note 3
    start = 1'b1; manual_en = 1'b1;
    push_melody("play_prio", 1'b0, 20);
    tick();
    start = 1'b0;
    for (int k = 1; k < 20; k++) tick();
    stop = 1'b1; manual_en = 1'b0;
    push("stop_note3", 32'd35815, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1);
    tick();
    stop = 1'b0;
    for (int k = 0; k < 3; k++) begin
      push("after_stop_no_done", 32'd35815, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1);
      tick();
    end

    // asynchronous Reset in the middle of note 1
    start = 1'b1;
    push_melody("pre_reset", 1'b0, 8);
    tick();
    start = 1'b0;
    for (int k = 1; k < 8; k++) tick();
    #2;
    Reset = 1'b1;
    #1;
    push("reset_mid_play", 32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1);
    compare_pop();
    @(negedge inclk);
    Reset = 1'b0;
    push("idle_after_reset", 32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1);
    tick();

`ifndef ORGAN_SEQ_LOOP_EN
    // full single pass; extra start pulses mid-melody must not disturb timing
    start = 1'b1;
    push_melody("melody", 1'b0, 48);
    push("done_pulse", 32'd0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0);
    tick();
    for (int k = 1; k < 49; k++) begin
      start = (k >= 10 && k < 13);
      tick();
    end
    start = 1'b0;
    push("post_done_idle", 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    tick();
`else
    // looping melody: done at 48 and 96 while busy stays high
    start = 1'b1;
    push_melody("loop_pass1", 1'b0, 48);
    push_melody("loop_pass2", 1'b1, 48);
    push("loop_done2", EXP_DIV[0], 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 1'b1);
    tick();
    start = 1'b0;
    for (int k = 1; k < 97; k++) tick();
    stop = 1'b1;
    push("loop_stop", 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1);
    tick();
    stop = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
